// File: rtl/spi_pkg.sv
// Shared SPI responder definitions: default widths, FSM state encoding, frame-layout helpers.
// Pure constants/functions; no timing or flow-control behaviour of its own.
package spi_pkg;

  localparam int DEF_CMD_WIDTH  = 12;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    RD_ARMED = 2'd2,
    RD_DATA  = 2'd3
  } spi_state_e;

  // The write/read flag is the first bit shifted in, so it lands in the MSB of the frame.
  function automatic int wr_flag_pos(input int cmd_width);
    return cmd_width - 1;
  endfunction

  function automatic int rd_cmd_len(input int addr_width);
    return 1 + addr_width;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop input synchronizer with registered rise/fall pulses; level/pulses lag the pin by STAGES+1 clk.
// No backpressure: free-running on every clk.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  // prev_q is aligned with the registered pulses, so level and edges describe the same sample.
  assign level = prev_q;

endmodule

// File: rtl/spi_slave_regs.sv
// Mode-0 SPI responder: 12-bit write frames into a register file, 4-bit read command then 8-bit read frame.
// Strobes fire SYNC_STAGES+2 clk after cs rise; no backpressure. SPI_SLV_RD_TIMEOUT_EN adds a 1023-clk RD_ARMED timeout.
module spi_slave_regs
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  wr_vld,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_done,
  output logic                  frame_err
);

  localparam int FLAG_POS = wr_flag_pos(CMD_WIDTH);
  localparam int RD_LEN   = rd_cmd_len(ADDR_WIDTH);
  localparam int CNT_W    = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam int NREGS    = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_CMD = CNT_W'(CMD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(RD_LEN);
  localparam logic [CNT_W-1:0] CNT_DAT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CMD_WIDTH + 1);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(cs), .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi), .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{cs_s, sclk_s, mosi_rise, mosi_fall};

  spi_state_e             state, state_nxt;
  logic [CMD_WIDTH-1:0]   rx_sr;
  logic [DATA_WIDTH-1:0]  tx_sr;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  regs [NREGS];
  logic clr_frame, rx_shift, cnt_inc, tx_shift, do_commit, do_arm, err_nxt, done_nxt;
  logic to_hit;

`ifdef SPI_SLV_RD_TIMEOUT_EN
  logic [9:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt <= '0;
    else if (state == RD_ARMED) to_cnt <= to_cnt + 10'd1;
    else                        to_cnt <= '0;
  end

  assign to_hit = (to_cnt == 10'h3FF);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // cs rise outranks cs fall, which outranks any sclk edge in the same clk.
  always_comb begin
    state_nxt = state;
    clr_frame = 1'b0;
    rx_shift  = 1'b0;
    cnt_inc   = 1'b0;
    tx_shift  = 1'b0;
    do_commit = 1'b0;
    do_arm    = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = CMD;
          clr_frame = 1'b1;
        end
      end
      CMD: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          if (bit_cnt == CNT_CMD && rx_sr[FLAG_POS]) begin
            do_commit = 1'b1;
          end else if (bit_cnt == CNT_RD && !rx_sr[RD_LEN-1]) begin
            do_arm    = 1'b1;
            state_nxt = RD_ARMED;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (!cs_fall && sclk_rise) begin
          rx_shift = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      RD_ARMED: begin
        if (cs_fall) begin
          state_nxt = RD_DATA;
          clr_frame = 1'b1;
        end else if (to_hit) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end
      end
      RD_DATA: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          done_nxt  = (bit_cnt == CNT_DAT);
          err_nxt   = (bit_cnt != CNT_DAT);
        end else if (!cs_fall) begin
          cnt_inc  = sclk_rise;
          tx_shift = sclk_fall;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      miso      <= 1'b0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_vld    <= do_commit;
      rd_done   <= done_nxt;
      frame_err <= err_nxt;
      if (clr_frame) begin
        rx_sr   <= '0;
        bit_cnt <= '0;
      end else begin
        if (rx_shift) rx_sr <= {rx_sr[CMD_WIDTH-2:0], mosi_s};
        if (cnt_inc && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
      if (do_commit) begin
        regs[rx_sr[DATA_WIDTH +: ADDR_WIDTH]] <= rx_sr[DATA_WIDTH-1:0];
        wr_addr <= rx_sr[DATA_WIDTH +: ADDR_WIDTH];
        wr_data <= rx_sr[DATA_WIDTH-1:0];
      end
      // Read data is snapshotted when the command frame closes.
      if (do_arm)        tx_sr <= regs[rx_sr[ADDR_WIDTH-1:0]];
      else if (tx_shift) tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      if (state_nxt != RD_DATA) miso <= 1'b0;
      else if (state != RD_DATA) miso <= tx_sr[DATA_WIDTH-1];
      else if (tx_shift)         miso <= tx_sr[DATA_WIDTH-2];
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs: frame-level reference model feeds a scoreboard checked by an output monitor.
// Covers writes, reads, malformed frames, reset mid-frame and (when enabled) the RD_ARMED timeout.
module tb_spi_slave_regs;

  localparam int AW = 3, DW = 8, CW = 12, SS = 2;
  localparam int HALF = 6, GAP = 8;
  localparam int K_WR = 0, K_RD = 1, K_ERR = 2;

  logic          clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic          miso, wr_vld, rd_done, frame_err;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  spi_slave_regs #(.CMD_WIDTH(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_done(rd_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int addr;
    int data;
    int t_ref;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0, miscompares = 0;
  int         model_regs[8];
  bit         armed = 1'b0;
  int         armed_data = 0;
  bit         in_rd = 1'b0, miso_bad = 1'b0;
  logic [7:0] rd_byte = '0;
  exp_t       mon_e;
  int         mon_k;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int addr, input int data, input int t_ref);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.t_ref = t_ref;
    sb.push_back(e);
  endtask

  // Output monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_rd && miso !== 1'b0) miso_bad = 1'b1;
      if (wr_vld || rd_done || frame_err) begin
        mon_k = wr_vld ? K_WR : (rd_done ? K_RD : K_ERR);
        chk("strobe_onehot", int'(wr_vld) + int'(rd_done) + int'(frame_err), 1);
        if (sb.size() == 0) begin
          chk("unexpected_event", mon_k, -1);
        end else begin
          mon_e = sb.pop_front();
          chk("event_kind", mon_k, mon_e.kind);
          if (mon_e.t_ref >= 0) chk("latency", cyc - mon_e.t_ref, SS + 2);
          if (mon_k == K_WR && mon_e.kind == K_WR) begin
            chk("wr_addr", int'(wr_addr), mon_e.addr);
            chk("wr_data", int'(wr_data), mon_e.data);
          end
          if (mon_k == K_RD && mon_e.kind == K_RD) chk("rd_data", int'(rd_byte), mon_e.data);
        end
      end
    end
  end

  // One cs window of len sclk cycles, MSB of bits[len-1:0] first; master samples miso on each rise.
  task automatic send_frame(input logic [15:0] bits, input int len);
    logic [7:0] cap;
    cap   = '0;
    in_rd = armed;
    cs    = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < len; i++) begin
      mosi = bits[len-1-i];
      wait_clk(HALF);
      cap  = {cap[6:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    mosi    = 1'b0;
    rd_byte = cap;
    if (armed) begin
      armed = 1'b0;
      if (len == 8) push(K_RD, 0, armed_data, cyc);
      else          push(K_ERR, 0, 0, cyc);
    end else if (len == 12 && bits[11]) begin
      model_regs[int'(bits[10:8])] = int'(bits[7:0]);
      push(K_WR, int'(bits[10:8]), int'(bits[7:0]), cyc);
    end else if (len == 4 && !bits[3]) begin
      armed      = 1'b1;
      armed_data = model_regs[int'(bits[2:0])];
    end else begin
      push(K_ERR, 0, 0, cyc);
    end
    cs = 1'b1;
    wait_clk(GAP);
    in_rd = 1'b0;
    chk("miso_idle", int'(miso_bad), 0);
    miso_bad = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
    armed = 1'b0;
    wait_clk(4);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    logic [15:0] bits;
    int          len, r;

    do_reset();
    chk("rst_wr_vld", int'(wr_vld), 0);
    chk("rst_rd_done", int'(rd_done), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_miso", int'(miso), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);

    // Read of addr 5 straight after reset returns 0.
    send_frame(16'h0005, 4);
    send_frame(16'h00FF, 8);
    // Write addr 3 = 0xA5, then read it back.
    send_frame(16'h0BA5, 12);
    send_frame(16'h0003, 4);
    send_frame(16'h0000, 8);
    // Short and long write frames are rejected and leave the registers alone.
    send_frame(16'h02C0, 10);
    send_frame(16'h17FF, 13);
    send_frame(16'h0003, 4);
    send_frame(16'h0000, 8);
    // Read data frame of the wrong length.
    send_frame(16'h0003, 4);
    send_frame(16'h0000, 5);

    // Reset after bit 6 of a write; only the following write may commit.
    cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 6; i++) begin
      mosi = (i == 0);
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    do_reset();
    send_frame(16'h093C, 12);
    send_frame(16'h0001, 4);
    send_frame(16'h0000, 8);
    send_frame(16'h0003, 4);
    send_frame(16'h0000, 8);

    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 99);
      bits = 16'($urandom);
      if (armed) begin
        len = (r < 85) ? 8 : $urandom_range(0, 11);
      end else if (r < 40) begin
        bits[11] = 1'b1;
        len = 12;
      end else if (r < 70) begin
        bits[3] = 1'b0;
        len = 4;
      end else begin
        len = $urandom_range(0, 14);
      end
      send_frame(bits, len);
    end
    if (armed) send_frame(16'h0000, 8);

`ifdef SPI_SLV_RD_TIMEOUT_EN
    send_frame(16'h0002, 4);
    push(K_ERR, 0, 0, -1);
    armed = 1'b0;
    wait_clk(1100);
    chk("timeout_fired", sb.size(), 0);
    send_frame(16'h0A5A, 12);
    send_frame(16'h0002, 4);
    send_frame(16'h0000, 8);
`endif

    wait_clk(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_slave_regs.md
Name: spi_slave_regs

Overview:
- SPI responder (mode 0, MSB-first) for the team's 12-bit-command SPI master.
- Oversamples sclk/cs/mosi on the system clk and decodes two frame types:
  - 12-bit write frame, which updates an internal register file.
  - 4-bit read-command frame, followed in a separate cs window by an 8-bit data frame shifted out on miso.
- Sits at the peripheral end of the link; used as the bench partner for the master and as a configuration-register front end.

Parameters:
- CMD_WIDTH, 12, write-frame length in bits (1 flag + ADDR_WIDTH + DATA_WIDTH).
- ADDR_WIDTH, 3, register address width; register file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, register and read-frame data width.
- SYNC_STAGES, 2, flops in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; frequency must be at least 8x sclk.
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock from master; idle low.
- cs  input  1  chip select, active low.
- mosi  input  1  master-out data.
- miso  output  1  slave-out data; driven 0 whenever not in a read data window.
- wr_vld  output  1  one-clk pulse when a write frame commits.
- wr_addr  output  ADDR_WIDTH  address of the last committed write.
- wr_data  output  DATA_WIDTH  data of the last committed write.
- rd_done  output  1  one-clk pulse when a read data frame completes.
- frame_err  output  1  one-clk pulse on any malformed frame.

Behaviour:
- Reset: all outputs 0; register file all 0; state IDLE; shift registers and bit counter 0; synchronizers load idle values (cs=1, sclk=0, mosi=0).
- Input handling:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronized samples: sclk rise, sclk fall, cs fall, cs rise.
- Event priority within a single clk: cs rise > cs fall > sclk edge. An sclk edge coinciding with a cs edge is ignored.
- Bit counter: ADDR_WIDTH+DATA_WIDTH+2 bits wide; saturates at CMD_WIDTH+1 (over-length detection).
- States:
  - IDLE:
    - cs fall -> CMD; clear rx shift register and bit_cnt.
    - sclk edges are ignored while cs is high.
  - CMD:
    - Each sclk rise: rx_sr <= {rx_sr, mosi_s}; bit_cnt increments (saturating).
    - On cs rise, with b0 = the first bit received:
      - bit_cnt==CMD_WIDTH and b0==1 -> commit write: reg[rx_sr addr field] <= rx_sr[DATA_WIDTH-1:0]. wr_addr/wr_data update and wr_vld pulses on the next clk. Go IDLE.
      - bit_cnt==1+ADDR_WIDTH and b0==0 -> latch rd_addr; tx_sr <= reg[rd_addr]; go RD_ARMED.
      - any other count/flag combination -> frame_err pulse next clk; go IDLE; no register change.
  - RD_ARMED: cs fall -> RD_DATA with miso = tx_sr MSB; clear bit_cnt.
  - RD_DATA:
    - sclk rise: bit_cnt++.
    - sclk fall: tx_sr shifts left; miso = new MSB.
    - mosi is ignored.
    - cs rise with bit_cnt==DATA_WIDTH -> rd_done pulse next clk; go IDLE.
    - cs rise with any other bit_cnt -> frame_err pulse; go IDLE.
- miso: registered; 0 in IDLE, CMD and RD_ARMED.
- A write to the address latched in RD_ARMED cannot occur, since the link is single-master and frames are serialized. Read data is the snapshot taken at the cs rise of the read command.
- Latency: wr_vld / rd_done / frame_err assert SYNC_STAGES+2 clk after the physical cs rise.
- Reset mid-frame: immediate return to IDLE and reset values; the partial frame is discarded silently.

Optional Feature:
- Macro: SPI_SLV_RD_TIMEOUT_EN.
- Defined:
  - A 10-bit counter runs in RD_ARMED.
  - If no cs fall arrives within 1023 clk, pulse frame_err and return to IDLE.
  - A later data frame is then handled as a normal CMD frame.
- Undefined: RD_ARMED waits indefinitely; no counter is synthesized.

Decomposition:
- Shared package spi_pkg:
  - state encoding localparams: IDLE=0, CMD=1, RD_ARMED=2, RD_DATA=3.
  - CMD_WIDTH, ADDR_WIDTH, DATA_WIDTH defaults.
  - write-flag bit position; read-command length.
- Sub-module spi_sync_edge: one instance per input. Provides the SYNC_STAGES synchronizer and emits the synchronized level plus rise/fall pulses.

Test Plan:
- Write frame 1_011_10100101 (addr 3, data 0xA5) -> wr_vld pulses once; wr_addr=3, wr_data=0xA5; miso stays 0 throughout.
- Write addr 3 = 0xA5, then read command 0_011, cs high gap, 8 sclk cycles -> master samples 0xA5 MSB-first; rd_done pulses once.
- Read command for addr 5 after reset, then 8 sclk cycles -> data 0x00; rd_done pulses.
- Write frame of 10 bits, and separately one of 13 bits -> frame_err pulses; no wr_vld; register contents unchanged (verified by readback).
- Assert rst_n low after bit 6 of a write frame, release, then send a full write addr 1 = 0x3C -> only the second write commits; readback of addr 1 = 0x3C.
- With SPI_SLV_RD_TIMEOUT_EN: read command, then hold cs high for 1100 clk -> frame_err at roughly clk 1023 of RD_ARMED; state returns to IDLE; a subsequent write frame is accepted.
